// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the order dispatcher: FSM state encoding,
// item index type, menu option decode and default preparation times.
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREP    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef logic [1:0] item_t;

    // Default preparation times in prep ticks, indexed by item (0..3 = item 1..4).
    localparam int PREP_T_DEFAULT [4] = '{10, 20, 30, 40};

    // True when exactly one option line is active.
    function automatic logic is_onehot(input logic [3:0] op);
        return (op != 4'b0000) && ((op & (op - 4'b0001)) == 4'b0000);
    endfunction

    // The menu drives its option lines mirrored: op[3] selects item 1.
    function automatic item_t decode_item(input logic [3:0] op);
        item_t idx;
        case (op)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            4'b0001: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Preparation time lookup for the latched item.
    function automatic int prep_ticks(input item_t idx, input int t1, input int t2,
                                      input int t3, input int t4);
        int ticks;
        case (idx)
            2'd0:    ticks = t1;
            2'd1:    ticks = t2;
            2'd2:    ticks = t3;
            default: ticks = t4;
        endcase
        return ticks;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one-cycle prep ticks, one every TICK_DIV cycles while
// clear is low. Holding clear high parks the counter at zero so the first
// tick of an order arrives a full TICK_DIV cycles after clear drops.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    // Free-running divider that restarts from zero on clear or after the last count.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = ~clear & (count == LAST);

endmodule

// File: rtl/order_dispatcher.sv
// Consumer end of the menu selection interface. A rising select flag with a
// valid one-hot option starts a timed preparation, then shows done_led and
// hands control back to the menu through clc. Invalid codes pulse err and go
// straight to the hand-back. Define ORDER_COUNT_EN to add the saturating
// served-orders counter and its port.
module order_dispatcher
    import dispatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000,
    parameter int CNT_W    = 8,
    parameter int PREP_T1  = PREP_T_DEFAULT[0],
    parameter int PREP_T2  = PREP_T_DEFAULT[1],
    parameter int PREP_T3  = PREP_T_DEFAULT[2],
    parameter int PREP_T4  = PREP_T_DEFAULT[3],
    parameter int DONE_CYC = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       op,
    input  logic             act,
    output logic             clc,
    output logic             busy,
    output logic             done_led,
    output logic             err,
    output logic [1:0]       item,
    output logic [CNT_W-1:0] remaining
`ifdef ORDER_COUNT_EN
    ,
    output logic [7:0]       served
`endif
);

    localparam int DW = (DONE_CYC > 1) ? $clog2(DONE_CYC) : 1;
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_CYC - 1);

    state_t          state;
    state_t          next_state;
    logic            act_q;
    logic            primed;
    logic            start;
    logic            op_valid;
    logic            load;
    logic            err_set;
    logic            tick;
    logic [DW-1:0]   done_cnt;

    // A select level already present when reset releases is not a new
    // selection, so edge detection waits one cycle for act_q to settle.
    assign start    = primed & act & ~act_q;
    assign op_valid = is_onehot(op);
    assign load     = (state == IDLE) & start & op_valid;
    assign err_set  = (state == IDLE) & start & ~op_valid;

    assign busy     = (state == PREP) | (state == DONE);
    assign done_led = (state == DONE);
    assign clc      = (state == RELEASE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != PREP),
        .tick    (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping act during an order aborts it silently.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = op_valid ? PREP : RELEASE;
            end
            PREP: begin
                if (!act)                   next_state = IDLE;
                else if (remaining == '0)   next_state = DONE;
            end
            DONE: begin
                if (!act)                   next_state = IDLE;
                else if (done_cnt == DONE_LAST) next_state = RELEASE;
            end
            RELEASE: begin
                if (!act) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Select edge detector and one-cycle error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q  <= 1'b0;
            primed <= 1'b0;
            err    <= 1'b0;
        end else begin
            act_q  <= act;
            primed <= 1'b1;
            err    <= err_set;
        end
    end

    // Item latch and prep-tick countdown; both hold their values across an abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            item      <= '0;
            remaining <= '0;
        end else if (load) begin
            item      <= decode_item(op);
            remaining <= CNT_W'(prep_ticks(decode_item(op), PREP_T1, PREP_T2, PREP_T3, PREP_T4));
        end else if ((state == PREP) && tick && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Counts cycles spent showing done_led.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt <= '0;
        end else if (state == DONE) begin
            done_cnt <= done_cnt + 1'b1;
        end else begin
            done_cnt <= '0;
        end
    end

`ifdef ORDER_COUNT_EN
    logic served_inc;

    assign served_inc = (state == DONE) & (next_state == RELEASE);

    // Completed-order counter, saturating at 255.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            served <= '0;
        end else if (served_inc && (served != 8'hFF)) begin
            served <= served + 1'b1;
        end
    end
`endif

endmodule
